// File: rtl/rr_arb_ctrl.sv
// Round-robin, packet-aware arbiter: merges N req/ack targets into one initiator stream.
// With PKT_LOCK set, the grant is held from a packet's first beat until its last beat transfers.
module rr_arb_ctrl #(
  parameter int N        = 4,
  parameter int SELW     = 2,
  parameter bit PKT_LOCK = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    t_req,
  input  logic [N-1:0]    t_last,
  output logic [N-1:0]    t_ack,
  output logic            i_req,
  input  logic            i_ack,
  output logic            i_last,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] sel,
  output logic            busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  localparam logic [N-1:0]    ONE_N    = N'(1);
  localparam logic [SELW-1:0] ONE_S    = SELW'(1);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;

  logic [N-1:0]    prio_mask;
  logic [N-1:0]    req_hi;
  logic [N-1:0]    req_pick;
  logic [N-1:0]    rr_gnt;
  logic [SELW-1:0] sel_enc;
  logic [SELW-1:0] ptr_adv;
  logic            xfer;

  // Requests at or above ptr take priority; if none, wrap to the lowest requester.
  always_comb begin
    prio_mask = {N{1'b1}} << ptr_q;
    req_hi    = t_req & prio_mask;
    req_pick  = (|req_hi) ? req_hi : t_req;
    rr_gnt    = req_pick & (~req_pick + ONE_N);
  end

  always_comb begin
    sel_enc = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) begin
        sel_enc = SELW'(k);
      end
    end
  end

  assign grant   = (state_q == LOCKED) ? gnt_q : rr_gnt;
  assign sel     = sel_enc;
  assign i_req   = |(t_req & grant);
  assign i_last  = |(t_last & grant);
  assign t_ack   = grant & {N{i_ack}};
  assign busy    = (state_q == LOCKED);
  assign xfer    = i_req & i_ack;
  assign ptr_adv = (sel_enc == LAST_IDX) ? '0 : sel_enc + ONE_S;

  // State and pointer move only on an actual transfer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (PKT_LOCK && !i_last) begin
            state_d = LOCKED;
            gnt_d   = grant;
          end else begin
            ptr_d = ptr_adv;
          end
        end
      end
      LOCKED: begin
        if (xfer && i_last) begin
          state_d = IDLE;
          ptr_d   = ptr_adv;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule
